// File: rtl/proc_pkg.sv
// Shared constants for the 2x2 matrix processor host sequencer.
// Opcode encodings, word field positions, host states and error words.
package proc_pkg;

  localparam int OPC_HI = 60;
  localparam int OPC_LO = 56;
  localparam int EW     = 7;

  localparam int A0 = 0;
  localparam int A1 = 7;
  localparam int A2 = 14;
  localparam int A3 = 21;
  localparam int B0 = 28;
  localparam int B1 = 35;
  localparam int B2 = 42;
  localparam int B3 = 49;

  typedef logic [OPC_HI-OPC_LO:0] opc_t;

  localparam opc_t OPC_ADD  = 5'b00001;
  localparam opc_t OPC_SUB  = 5'b00010;
  localparam opc_t OPC_MUL  = 5'b00100;
  localparam opc_t OPC_TRAN = 5'b01000;
  localparam opc_t OPC_DET  = 5'b10000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FIN
  } hstate_t;

  localparam logic [31:0] ERR_INST = 32'hE000_0000;
  localparam logic [31:0] ERR_TMO  = 32'hF000_0000;

endpackage

// File: rtl/proc_inst_check.sv
// Opcode screen: only the five one-hot encodings reach the processor.
// Anything else would be silently dropped by it, so it is flagged here.
module proc_inst_check
  import proc_pkg::*;
(
  input  opc_t opc,
  output logic valid
);

  always_comb begin
    valid = 1'b0;
    unique case (1'b1)
      (opc == OPC_ADD):  valid = 1'b1;
      (opc == OPC_SUB):  valid = 1'b1;
      (opc == OPC_MUL):  valid = 1'b1;
      (opc == OPC_TRAN): valid = 1'b1;
      (opc == OPC_DET):  valid = 1'b1;
      default:           valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_host_seq.sv
// Host sequencer: fetch, screen, issue, await done, write back.
// Control outputs decode straight from state; data lives in registers.
module proc_host_seq
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   n_inst,
  output logic              busy,
  output logic              finish,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [63:0]       imem_rdata,
  output logic              rmem_we,
  output logic [ADDR_W-1:0] rmem_addr,
  output logic [31:0]       rmem_wdata,
  output logic              inst_valid,
  output logic [63:0]       p_rdata,
  input  logic [31:0]       p_wdata,
  input  logic              done
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] NMAX = {1'b1, {ADDR_W{1'b0}}};

  hstate_t           state;
  hstate_t           state_n;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   n_q;
  logic [TW-1:0]     tmo;
  logic [31:0]       result;
  logic              opc_ok;
  logic              last;
  logic              tmo_hit;

  proc_inst_check u_chk (
    .opc   (imem_rdata[OPC_HI:OPC_LO]),
    .valid (opc_ok)
  );

  assign last       = ({1'b0, idx} + 1'b1) == n_q;
  // WRITE lands TIMEOUT cycles after ISSUE
  assign tmo_hit    = tmo == TW'(TIMEOUT - 2);
  assign imem_addr  = idx;
  assign rmem_addr  = idx;
  assign rmem_wdata = result;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = (n_inst == '0) ? S_FIN : S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: state_n = opc_ok ? S_ISSUE : S_WRITE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (done || tmo_hit) state_n = S_WRITE;
      S_WRITE: state_n = last ? S_FIN : S_FETCH;
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = state != S_IDLE;
    inst_valid = state == S_ISSUE;
    rmem_we    = state == S_WRITE;
    finish     = state == S_FIN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      n_q     <= '0;
      tmo     <= '0;
      result  <= '0;
      p_rdata <= '0;
      err_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q     <= (n_inst > NMAX) ? NMAX : n_inst;
            idx     <= '0;
            err_cnt <= '0;
          end
        end
        S_LATCH: begin
          p_rdata <= imem_rdata;
          if (!opc_ok) begin
            result  <= ERR_INST;
            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
          end
        end
        S_ISSUE: tmo <= '0;
        S_WAIT: begin
          if (done) begin
            result <= p_wdata;
          end else if (tmo_hit) begin
            result  <= ERR_TMO;
            err_cnt <= (&err_cnt) ? err_cnt : err_cnt + 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_WRITE: if (!last) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_host_seq.sv
// Bench for proc_host_seq with a behavioural 2x2 processor and memories.
// Expected writes and timing come from per-instruction cycle costs.
module tb_proc_host_seq;

  localparam int AW  = 6;
  localparam int TMO = 16;
  localparam int CW  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   n_inst = '0;
  logic          busy, finish, rmem_we, inst_valid;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] imem_addr, rmem_addr;
  logic [63:0]   imem_rdata, p_rdata;
  logic [31:0]   rmem_wdata;
  logic [31:0]   p_wdata = '0;
  logic          done = 1'b0;

  always #5 clk = ~clk;

  proc_host_seq #(.ADDR_W(AW), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_inst(n_inst),
    .busy(busy), .finish(finish), .err_cnt(err_cnt),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .rmem_we(rmem_we), .rmem_addr(rmem_addr), .rmem_wdata(rmem_wdata),
    .inst_valid(inst_valid), .p_rdata(p_rdata),
    .p_wdata(p_wdata), .done(done)
  );

  logic [63:0] imem [64];
  always @(posedge clk) imem_rdata <= imem[imem_addr];

  function automatic logic [31:0] calc(input logic [63:0] w);
    int a[4], b[4], r[4];
    logic [4:0]  op;
    logic [31:0] o;
    for (int k = 0; k < 4; k++) begin
      a[k] = int'(w[7*k +: 7]);
      b[k] = int'(w[28 + 7*k +: 7]);
      r[k] = 0;
    end
    op = w[60:56];
    case (op)
      5'b00001: for (int k = 0; k < 4; k++) r[k] = a[k] + b[k];
      5'b00010: for (int k = 0; k < 4; k++) r[k] = a[k] - b[k];
      5'b00100: begin
        r[0] = a[0]*b[0] + a[1]*b[2];
        r[1] = a[0]*b[1] + a[1]*b[3];
        r[2] = a[2]*b[0] + a[3]*b[2];
        r[3] = a[2]*b[1] + a[3]*b[3];
      end
      5'b01000: begin
        r[0] = a[0]; r[1] = a[2]; r[2] = a[1]; r[3] = a[3];
      end
      5'b10000: r[0] = a[0]*a[3] - a[1]*a[2];
      default: ;
    endcase
    o = '0;
    for (int k = 0; k < 4; k++) o[7*k +: 7] = 7'(r[k]);
    return o;
  endfunction

  function automatic logic [63:0] mk(input logic [4:0] op,
                                     input logic [27:0] av,
                                     input logic [27:0] bv);
    return {3'b000, op, bv, av};
  endfunction

  // Processor stand-in: done on the 4th cycle after the issue pulse
  bit          stub = 1'b0;
  bit          pend = 1'b0;
  int          dly = 0;
  logic [63:0] pw;
  always @(posedge clk) begin
    done <= 1'b0;
    if (!rst_n) begin
      pend <= 1'b0;
    end else if (inst_valid && !stub) begin
      pend <= 1'b1;
      dly  <= 0;
      pw   <= p_rdata;
    end else if (pend) begin
      if (dly == 2) begin
        done    <= 1'b1;
        p_wdata <= calc(pw);
        pend    <= 1'b0;
      end
      dly <= dly + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  int          exp_n, exp_fin, exp_iv, exp_err;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            got_cyc[$];
  int            got_iv, got_fin, got_busy, got_err;
  bit            got_imem;

  localparam logic [27:0] AV = {7'd4, 7'd3, 7'd2, 7'd1};
  localparam logic [27:0] BV = {7'd8, 7'd7, 7'd6, 7'd5};

  // Cycle cost per instruction: valid 8, lost 3+TMO, invalid 3
  task automatic model(input int n, input bit stb);
    int c, ne, e;
    logic [4:0] op;
    exp_data.delete();
    exp_cyc.delete();
    ne = (n > 64) ? 64 : n;
    c = 1; e = 0; exp_iv = 0;
    for (int i = 0; i < ne; i++) begin
      op = imem[i][60:56];
      if ($countones(op) == 1 && !stb) begin
        exp_data.push_back(calc(imem[i]));
        exp_cyc.push_back(c + 7);
        c += 8; exp_iv++;
      end else if ($countones(op) == 1) begin
        exp_data.push_back(32'hF000_0000);
        exp_cyc.push_back(c + 2 + TMO);
        c += 3 + TMO; e++; exp_iv++;
      end else begin
        exp_data.push_back(32'hE000_0000);
        exp_cyc.push_back(c + 2);
        c += 3; e++;
      end
    end
    exp_n   = ne;
    exp_fin = c;
    exp_err = (e > (1 << CW) - 1) ? (1 << CW) - 1 : e;
  endtask

  task automatic run_prog(input int n, input bit stb,
                          input int budget, input int re_at);
    stub = stb;
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    got_iv = 0; got_fin = -1; got_busy = 0; got_err = -1;
    got_imem = 1'b0;
    start = 1'b1;
    n_inst = 7'(n);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      start = (k == re_at);
      if (k == re_at) n_inst = 7'd1;
      if (rmem_we) begin
        got_addr.push_back(rmem_addr);
        got_data.push_back(rmem_wdata);
        got_cyc.push_back(k);
      end
      if (inst_valid) got_iv++;
      if (busy) got_busy++;
      if (imem_addr != '0) got_imem = 1'b1;
      if (finish) begin
        got_fin = k;
        got_err = int'(err_cnt);
        break;
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, finish, rmem_we, inst_valid} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_ctl: got %b want 0000",
               {busy, finish, rmem_we, inst_valid});
    end
    n_cmp++;
    if (err_cnt !== '0) begin
      n_bad++; $display("FAIL rst_err: got %0d want 0", err_cnt);
    end
    n_cmp++;
    if ({imem_addr, rmem_addr} !== '0) begin
      n_bad++;
      $display("FAIL rst_addr: got %h/%h want 0", imem_addr, rmem_addr);
    end
    n_cmp++;
    if (rmem_wdata !== '0 || p_rdata !== '0) begin
      n_bad++;
      $display("FAIL rst_data: got %h/%h want 0", rmem_wdata, p_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add;
    imem[0] = mk(5'b00001, AV, BV);
    model(1, 0);
    run_prog(1, 0, 100, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 32'h0182_8406
        || got_addr[0] !== '0) begin
      n_bad++;
      $display("FAIL add_res: got n=%0d %h want 1 01828406",
               got_data.size(), got_data[0]);
    end
    n_cmp++;
    if (got_iv != 1) begin
      n_bad++; $display("FAIL add_iv: got %0d want 1", got_iv);
    end
    n_cmp++;
    if (got_fin != exp_fin || got_cyc[0] != exp_cyc[0]) begin
      n_bad++;
      $display("FAIL add_time: got fin %0d wr %0d want %0d %0d",
               got_fin, got_cyc[0], exp_fin, exp_cyc[0]);
    end
    n_cmp++;
    if (got_err != 0) begin
      n_bad++; $display("FAIL add_err: got %0d want 0", got_err);
    end
  endtask

  task automatic test_program3;
    logic [31:0] want[3];
    want[0] = 32'(19 | (22 << 7) | (43 << 14) | (50 << 21));
    want[1] = 32'(1 | (3 << 7) | (2 << 14) | (4 << 21));
    want[2] = 32'h0000_007E;
    imem[0] = mk(5'b00100, AV, BV);
    imem[1] = mk(5'b01000, AV, BV);
    imem[2] = mk(5'b10000, AV, BV);
    model(3, 0);
    run_prog(3, 0, 200, 0);
    n_cmp++;
    if (got_data.size() != 3) begin
      n_bad++; $display("FAIL p3_cnt: got %0d want 3", got_data.size());
    end
    for (int i = 0; i < got_data.size() && i < 3; i++) begin
      n_cmp++;
      if (got_data[i] !== want[i] || got_addr[i] !== AW'(i)) begin
        n_bad++;
        $display("FAIL p3_wr%0d: got @%0d %h want @%0d %h",
                 i, got_addr[i], got_data[i], i, want[i]);
      end
    end
    n_cmp++;
    if (got_cyc[1] - got_cyc[0] != 8 || got_cyc[2] - got_cyc[1] != 8
        || got_fin != exp_fin) begin
      n_bad++;
      $display("FAIL p3_time: got %0d %0d %0d fin %0d want 8 apart fin %0d",
               got_cyc[0], got_cyc[1], got_cyc[2], got_fin, exp_fin);
    end
  endtask

  task automatic test_invalid;
    imem[0] = mk(5'b00011, AV, BV);
    imem[1] = mk(5'b00001, AV, BV);
    model(2, 0);
    run_prog(2, 0, 100, 0);
    n_cmp++;
    if (got_iv != 1) begin
      n_bad++; $display("FAIL inv_iv: got %0d want 1", got_iv);
    end
    n_cmp++;
    if (got_data.size() != 2 || got_data[0] !== 32'hE000_0000
        || got_data[1] !== 32'h0182_8406) begin
      n_bad++;
      $display("FAIL inv_res: got n=%0d %h %h want E0000000 01828406",
               got_data.size(), got_data[0], got_data[1]);
    end
    n_cmp++;
    if (got_err != 1 || got_cyc[0] != exp_cyc[0] || got_fin != exp_fin) begin
      n_bad++;
      $display("FAIL inv_err: got err %0d wr %0d fin %0d want 1 %0d %0d",
               got_err, got_cyc[0], got_fin, exp_cyc[0], exp_fin);
    end
  endtask

  task automatic test_timeout;
    imem[0] = mk(5'b00001, AV, BV);
    model(1, 1);
    run_prog(1, 1, 200, 0);
    n_cmp++;
    if (got_data.size() != 1 || got_data[0] !== 32'hF000_0000) begin
      n_bad++;
      $display("FAIL tmo_res: got n=%0d %h want F0000000",
               got_data.size(), got_data[0]);
    end
    n_cmp++;
    if (got_cyc[0] != 3 + TMO || got_fin != 4 + TMO || got_err != 1) begin
      n_bad++;
      $display("FAIL tmo_time: got wr %0d fin %0d err %0d want %0d %0d 1",
               got_cyc[0], got_fin, got_err, 3 + TMO, 4 + TMO);
    end
    stub = 1'b0;
  endtask

  task automatic test_zero;
    run_prog(0, 0, 20, 0);
    n_cmp++;
    if (got_fin != 1 || got_busy != 1) begin
      n_bad++;
      $display("FAIL zero_fin: got fin %0d busy %0d want 1 1",
               got_fin, got_busy);
    end
    n_cmp++;
    if (got_data.size() != 0 || got_iv != 0 || got_imem) begin
      n_bad++;
      $display("FAIL zero_act: got wr %0d iv %0d imem %0d want 0 0 0",
               got_data.size(), got_iv, got_imem);
    end
  endtask

  task automatic test_mid_reset;
    int nw, nf;
    nw = 0; nf = 0;
    imem[0] = mk(5'b00100, AV, BV);
    imem[1] = mk(5'b01000, AV, BV);
    imem[2] = mk(5'b10000, AV, BV);
    stub = 1'b0;
    start = 1'b1;
    n_inst = 7'd3;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 14) begin
        n_cmp++;
        if ({busy, finish, rmem_we, inst_valid, err_cnt,
             imem_addr, rmem_addr} !== '0
            || rmem_wdata !== '0 || p_rdata !== '0) begin
          n_bad++;
          $display("FAIL mrst_out: got busy %b idx %0d wd %h pd %h want 0",
                   busy, imem_addr, rmem_wdata, p_rdata);
        end
        rst_n = 1'b1;
      end
      if (rmem_we) nw++;
      if (finish) nf++;
      if (k == 13) rst_n = 1'b0;
    end
    n_cmp++;
    if (nw != 1 || nf != 0) begin
      n_bad++;
      $display("FAIL mrst_quiet: got writes %0d fin %0d want 1 0", nw, nf);
    end
    model(3, 0);
    run_prog(3, 0, 200, 0);
    n_cmp++;
    if (got_data.size() != exp_n || got_fin != exp_fin) begin
      n_bad++;
      $display("FAIL mrst_rerun: got n %0d fin %0d want %0d %0d",
               got_data.size(), got_fin, exp_n, exp_fin);
    end
    for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
      n_cmp++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]
          || got_cyc[i] != exp_cyc[i]) begin
        n_bad++;
        $display("FAIL mrst_wr%0d: got @%0d %h c%0d want @%0d %h c%0d",
                 i, got_addr[i], got_data[i], got_cyc[i],
                 i, exp_data[i], exp_cyc[i]);
      end
    end
  endtask

  task automatic test_random;
    int n, ra;
    bit stb;
    logic [4:0] op;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 12);
      stb = ($urandom_range(0, 3) == 0);
      ra = (it == 2) ? 5 : 0;
      for (int i = 0; i < n; i++) begin
        op = ($urandom_range(0, 9) < 7) ? 5'(1 << $urandom_range(0, 4))
                                        : 5'($urandom_range(0, 31));
        imem[i] = {$urandom, $urandom};
        imem[i][60:56] = op;
      end
      model(n, stb);
      run_prog(n, stb, 1000, ra);
      n_cmp++;
      if (got_data.size() != exp_n || got_fin != exp_fin
          || got_iv != exp_iv || got_err != exp_err) begin
        n_bad++;
        $display("FAIL rnd%0d_sum: got n%0d f%0d iv%0d e%0d want %0d %0d %0d %0d",
                 it, got_data.size(), got_fin, got_iv, got_err,
                 exp_n, exp_fin, exp_iv, exp_err);
      end
      for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
        n_cmp++;
        if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]
            || got_cyc[i] != exp_cyc[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_wr%0d: got @%0d %h c%0d want %h c%0d",
                   it, i, got_addr[i], got_data[i], got_cyc[i],
                   exp_data[i], exp_cyc[i]);
        end
      end
    end
    stub = 1'b0;
  endtask

  task automatic test_clamp;
    for (int i = 0; i < 64; i++) imem[i] = {$urandom, $urandom};
    model(100, 0);
    run_prog(100, 0, 3000, 0);
    n_cmp++;
    if (got_data.size() != 64 || got_fin != exp_fin) begin
      n_bad++;
      $display("FAIL clamp_n: got n %0d fin %0d want 64 %0d",
               got_data.size(), got_fin, exp_fin);
    end
    n_cmp++;
    if (got_err != exp_err) begin
      n_bad++;
      $display("FAIL clamp_sat: got %0d want %0d", got_err, exp_err);
    end
    for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
      n_cmp++;
      if (got_addr[i] !== AW'(i) || got_data[i] !== exp_data[i]) begin
        n_bad++;
        $display("FAIL clamp_wr%0d: got @%0d %h want @%0d %h",
                 i, got_addr[i], got_data[i], i, exp_data[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = '0;
    test_reset();
    test_single_add();
    test_program3();
    test_invalid();
    test_timeout();
    test_zero();
    test_mid_reset();
    test_random();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end by 2ms want summary");
    $fatal(1, "watchdog");
  end

endmodule
